// File: rtl/ram8_arbiter_if.sv
// Requester-side bus of ram8_arbiter: two req/gnt ports plus shared read data and busy.
// The arbiter takes the slave modport; the requesters (or a bench) take the master modport.
interface ram8_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [2:0]  a_addr;
    logic [15:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [2:0]  b_addr;
    logic [15:0] b_wdata;
    logic        a_gnt;
    logic        b_gnt;
    logic        a_rvalid;
    logic        b_rvalid;
    logic [15:0] rdata;
    logic        busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy
    );
endinterface

// File: rtl/ram8_arbiter.sv
// Fair two-port arbiter/sequencer in front of a single RAM8 (8 x 16-bit).
// Define RAM8_ARB_INIT_EN to zero-fill all 8 words after every reset (busy high meanwhile).
module ram8_arbiter (
    input  logic                 clk,
    input  logic                 rst_n,
    ram8_arbiter_if.slave        bus,
    output logic [2:0]           ram_addr,
    output logic [15:0]          ram_in,
    output logic                 ram_write,
    input  logic [15:0]          ram_out
);

`ifdef RAM8_ARB_INIT_EN
    typedef enum logic [1:0] {StIdle, StGntA, StGntB, StInit} state_e;
    localparam state_e ResetState = StInit;
`else
    typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;
    localparam state_e ResetState = StIdle;
`endif

    state_e      state_q, state_d;
    logic        last_b_q, last_b_d;  // 1: B was granted most recently
    logic [15:0] rdata_q;
    logic        a_rvalid_q, b_rvalid_q;
    logic        a_gnt, b_gnt;

`ifdef RAM8_ARB_INIT_EN
    logic [2:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else if (state_q == StInit) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ResetState;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.a_req && bus.b_req) begin
                    state_d = last_b_q ? StGntA : StGntB;
                end else if (bus.a_req) begin
                    state_d = StGntA;
                end else if (bus.b_req) begin
                    state_d = StGntB;
                end
            end
            StGntA: state_d = bus.b_req ? StGntB : StIdle;
            StGntB: state_d = bus.a_req ? StGntA : StIdle;
`ifdef RAM8_ARB_INIT_EN
            StInit: if (cnt_q == 3'd7) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

        last_b_d = last_b_q;
        if (state_d == StGntA) last_b_d = 1'b0;
        if (state_d == StGntB) last_b_d = 1'b1;
    end

    always_comb begin
        ram_addr  = 3'd0;
        ram_in    = 16'd0;
        ram_write = 1'b0;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        unique case (state_q)
            StGntA: begin
                ram_addr  = bus.a_addr;
                ram_in    = bus.a_wdata;
                ram_write = bus.a_we;
                a_gnt     = 1'b1;
            end
            StGntB: begin
                ram_addr  = bus.b_addr;
                ram_in    = bus.b_wdata;
                ram_write = bus.b_we;
                b_gnt     = 1'b1;
            end
`ifdef RAM8_ARB_INIT_EN
            StInit: begin
                ram_addr  = cnt_q;
                // Reset parks in StInit; keep the RAM write pin quiet until rst_n releases.
                ram_write = rst_n;
            end
`endif
            default: ;
        endcase
    end

    // Read data is captured at the edge that ends the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= 16'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= (state_q == StGntA) && !bus.a_we;
            b_rvalid_q <= (state_q == StGntB) && !bus.b_we;
            if (((state_q == StGntA) && !bus.a_we) || ((state_q == StGntB) && !bus.b_we)) begin
                rdata_q <= ram_out;
            end
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.rdata    = rdata_q;
`ifdef RAM8_ARB_INIT_EN
    assign bus.busy     = (state_q == StInit);
`else
    assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_ram8_arbiter.sv
// Scoreboard bench for ram8_arbiter with a behavioural RAM8 behind it.
// Honours RAM8_ARB_INIT_EN when the RTL is built with it.
module tb_ram8_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ram_addr;
    logic [15:0] ram_in;
    logic [15:0] ram_out;
    logic        ram_write;

    always #5 clk = ~clk;

    ram8_arbiter_if bus ();

    ram8_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_in    (ram_in),
        .ram_write (ram_write),
        .ram_out   (ram_out)
    );

    logic [15:0] mem [8];
    assign ram_out = mem[ram_addr];
    always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] shadow [8];
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    bit          gnt_log [$];
    logic        pend_a, pend_b, prev_a, prev_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Grant exclusivity, no back-to-back grant, rvalid timing and read data.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            if (bus.a_gnt && bus.b_gnt) check("gnt_both", 32'(bus.a_gnt & bus.b_gnt), 32'(0));
            if (bus.a_gnt) begin
                check("a_gnt_repeat", 32'(prev_a), 32'(0));
                gnt_log.push_back(1'b0);
            end
            if (bus.b_gnt) begin
                check("b_gnt_repeat", 32'(prev_b), 32'(0));
                gnt_log.push_back(1'b1);
            end
            if (pend_a || bus.a_rvalid) check("a_rvalid", 32'(bus.a_rvalid), 32'(pend_a));
            if (pend_b || bus.b_rvalid) check("b_rvalid", 32'(bus.b_rvalid), 32'(pend_b));
            if (bus.a_rvalid) begin
                if (exp_a.size() == 0) check("a_rvalid_unexpected", 32'(bus.a_rvalid), 32'(0));
                else check("a_rdata", 32'(bus.rdata), 32'(exp_a.pop_front()));
            end
            if (bus.b_rvalid) begin
                if (exp_b.size() == 0) check("b_rvalid_unexpected", 32'(bus.b_rvalid), 32'(0));
                else check("b_rdata", 32'(bus.rdata), 32'(exp_b.pop_front()));
            end
            pend_a <= bus.a_gnt && !bus.a_we;
            pend_b <= bus.b_gnt && !bus.b_we;
            prev_a <= bus.a_gnt;
            prev_b <= bus.b_gnt;
        end
    end

    // Presents one request after a rising edge and returns at the negedge of its gnt cycle.
    task automatic do_req(input bit port, input logic we, input logic [2:0] addr,
                          input logic [15:0] data, output int lat);
        logic g;
        @(posedge clk);
        #1;
        if (port) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
        end
        if (we) shadow[addr] = data;
        else if (port) exp_b.push_back(shadow[addr]);
        else exp_a.push_back(shadow[addr]);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            g = port ? bus.b_gnt : bus.a_gnt;
        end while (!g && lat < 20);
        if (!g) check(port ? "b_gnt_timeout" : "a_gnt_timeout", 32'(g), 32'(1));
    endtask

    task automatic release_req(input bit port);
        @(posedge clk);
        #1;
        if (port) bus.b_req = 1'b0;
        else bus.a_req = 1'b0;
    endtask

    // Called just after reset release at a negedge.
    task automatic wait_init();
`ifdef RAM8_ARB_INIT_EN
        int n = 0;
        #1;
        while (bus.busy && n < 20) begin
            check("init_addr", 32'(ram_addr), 32'(n % 8));
            check("init_write", 32'(ram_write), 32'(1));
            n++;
            @(negedge clk);
            #1;
        end
        check("init_cycles", 32'(n), 32'(8));
        for (int i = 0; i < 8; i++) shadow[i] = 16'h0000;
`else
        #1;
        check("busy_idle", 32'(bus.busy), 32'(0));
`endif
    endtask

    initial begin
        int lat, lat_a, lat_b;
        rst_n = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 3'd0; bus.a_wdata = 16'd0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 3'd0; bus.b_wdata = 16'd0;
        @(negedge clk);
        check("rst_a_gnt", 32'(bus.a_gnt), 32'(0));
        check("rst_b_gnt", 32'(bus.b_gnt), 32'(0));
        check("rst_a_rvalid", 32'(bus.a_rvalid), 32'(0));
        check("rst_b_rvalid", 32'(bus.b_rvalid), 32'(0));
        check("rst_rdata", 32'(bus.rdata), 32'(0));
        check("rst_ram_write", 32'(ram_write), 32'(0));
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_ram_in", 32'(ram_in), 32'(0));
`ifdef RAM8_ARB_INIT_EN
        check("rst_busy", 32'(bus.busy), 32'(1));
`else
        check("rst_busy", 32'(bus.busy), 32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        // Simultaneous requests: A wins the first tie, then strict alternation.
        gnt_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 3'(i), 16'(16'h0a00 + i), lat_a);
                release_req(1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) do_req(1'b1, 1'b1, 3'(4 + i), 16'(16'h0b00 + i), lat_b);
                release_req(1'b1);
            end
        join
        check("alt_count", 32'(gnt_log.size()), 32'(7));
        for (int i = 0; i < gnt_log.size(); i++) check("alt_order", 32'(gnt_log[i]), 32'(i % 2));

        // Single write then read by A.
        do_req(1'b0, 1'b1, 3'd5, 16'hBEEF, lat);
        check("gnt_latency", 32'(lat), 32'(2));
        do_req(1'b0, 1'b0, 3'd5, 16'h0000, lat);
        release_req(1'b0);

        // Cross-port coherence.
        do_req(1'b1, 1'b1, 3'd7, 16'h1234, lat);
        release_req(1'b1);
        do_req(1'b0, 1'b0, 3'd7, 16'h0000, lat);
        release_req(1'b0);

        // Lone requester holding req: grants only on alternate cycles.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 1'b0, 3'(i), 16'h0000, lat);
            check("lone_latency", 32'(lat), 32'(2));
        end
        release_req(1'b0);

        // Reset in the middle of a write grant.
        do_req(1'b0, 1'b1, 3'd2, 16'h0001, lat);
        do_req(1'b0, 1'b1, 3'd2, 16'hFFFF, lat);
        check("mid_gnt_seen", 32'(bus.a_gnt), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ram_write", 32'(ram_write), 32'(0));
        check("mid_a_gnt", 32'(bus.a_gnt), 32'(0));
        check("mid_ram_addr", 32'(ram_addr), 32'(0));
        shadow[2] = 16'h0001;
        bus.a_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        for (int i = 0; i < 8; i++) do_req(1'b0, 1'b0, 3'(i), 16'h0000, lat);
        release_req(1'b0);
        repeat (3) @(negedge clk);
        check("a_scoreboard_drained", 32'(exp_a.size()), 32'(0));
        check("b_scoreboard_drained", 32'(exp_b.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
